// File: rtl/gumnut_bus_pkg.sv
// Shared definitions for the Gumnut data-bus responder.
//   dmem_state_e : responder FSM states (IDLE, WAIT, ACK)
//   DATA_W       : data bus width (8)
//   ADDR_W       : address bus width (8)
//   WAIT_CNT_W   : wait-state counter width (4, covers 0..15)
//   MEM_W        : stored word width; 9 when GUMNUT_DMEM_PARITY_EN is
//                  defined (data + even parity bit), otherwise 8
package gumnut_bus_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int WAIT_CNT_W = 4;

`ifdef GUMNUT_DMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/gumnut_data_mem_if.sv
// Gumnut core data bus bundle (cyc/stb/we/adr/dat/ack/err).
//   master modport : drives cyc, stb, we, adr, dat_w; receives dat_r, ack, err
//   slave modport  : the reverse
//
// Handshake: a transfer is requested while cyc & stb are high. The responder
// samples the request only while idle and answers with a single-cycle ack
// (err alongside it for a bad read). The master keeps cyc high until it sees
// ack and drops stb once the request has been taken; dropping cyc before ack
// abandons the transfer (no write, no ack). Read data is valid with ack and
// stays put until the next read is acknowledged.
interface gumnut_data_mem_if;

  logic                              cyc;
  logic                              stb;
  logic                              we;
  logic [gumnut_bus_pkg::ADDR_W-1:0] adr;
  logic [gumnut_bus_pkg::DATA_W-1:0] dat_w;
  logic [gumnut_bus_pkg::DATA_W-1:0] dat_r;
  logic                              ack;
  logic                              err;

  modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack, err);

endinterface

// File: rtl/gumnut_dmem_array.sv
// Synchronous single-port RAM behind the Gumnut data responder.
//   clk, rst_n : clock, async active-low reset (clears the read register only)
//   en         : clock enable; nothing changes while low
//   re         : load rdata from mem[addr] on the next enabled edge
//   we         : write wdata to mem[addr] on the next enabled edge
//   addr       : word address (AW bits)
//   wdata      : write word (MEM_W bits)
//   rdata      : registered read word, holds between reads
// The array contents are not reset.
module gumnut_dmem_array
  import gumnut_bus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             re,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [MEM_W-1:0] wdata,
  output logic [MEM_W-1:0] rdata
);

  logic [MEM_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/gumnut_data_mem.sv
// Gumnut core data-bus responder: byte-wide RAM answering loads/stores after
// a programmable number of wait states.
//   clk_i, rst_ni  : clock, async active-low reset
//   clk_en_i       : clock enable; all state holds while low
//   cyc_i, stb_i   : bus cycle / strobe from the core data master
//   we_i           : 1 = write, 0 = read
//   adr_i, dat_i   : byte address and write data
//   dat_o          : registered read data, updated only by read acks
//   ack_o          : one-cycle transfer acknowledge
//   err_o          : read parity error, coincident with ack_o
//   state_o        : FSM state, for observation
// Parameters: DEPTH (power of two, 2..256), WAIT_STATES (0..15).
// Optional feature macro GUMNUT_DMEM_PARITY_EN: store an even-parity bit per
// byte and flag mismatches on reads; without it err_o is tied low.
module gumnut_data_mem
  import gumnut_bus_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clk_en_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o,
  output logic              err_o,
  output dmem_state_e       state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);

  dmem_state_e           state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  lat_we;
  logic [AW-1:0]         lat_adr;
  logic [DATA_W-1:0]     lat_dat;
  logic                  ack;

  logic                  req;
  logic                  enter_ack;
  logic                  is_read;
  logic                  ram_re;
  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [MEM_W-1:0]      ram_wdata;
  logic [MEM_W-1:0]      ram_rdata;

  // Upper address bits alias onto the array; they are deliberately dropped.
  logic unused_adr;
  assign unused_adr = ^adr_i;

  assign req = cyc_i & stb_i;

  // Edge that moves the FSM into ACK: straight from IDLE when there are no
  // wait states, otherwise on the last WAIT cycle unless cyc_i was dropped.
  assign enter_ack = ((state == IDLE) && req && ZERO_WAIT) ||
                     ((state == WAIT) && cyc_i && (cnt == WAIT_CNT_W'(1)));

  // In IDLE the live bus is used (zero-wait case), afterwards the latched copy.
  assign is_read  = (state == IDLE) ? ~we_i : ~lat_we;
  assign ram_addr = (state == IDLE) ? adr_i[AW-1:0] : lat_adr;

  // The RAM read register is dat_o itself, so it is loaded only on the edge
  // entering ACK of a read and otherwise holds its value.
  assign ram_re = enter_ack & is_read;
  // Writes commit on the edge leaving ACK; an abort or reset never gets here.
  assign ram_we = (state == ACK) & lat_we;

`ifdef GUMNUT_DMEM_PARITY_EN
  assign ram_wdata = {^lat_dat, lat_dat};
  // Stored word is even parity over all 9 bits; any odd result is corruption.
  assign err_o     = ack & ~lat_we & (^ram_rdata);
`else
  assign ram_wdata = lat_dat;
  assign err_o     = 1'b0;
`endif

  assign dat_o   = ram_rdata[DATA_W-1:0];
  assign ack_o   = ack;
  assign state_o = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_we  <= 1'b0;
      lat_adr <= '0;
      lat_dat <= '0;
      ack     <= 1'b0;
    end else if (clk_en_i) begin
      ack <= enter_ack;
      case (state)
        IDLE: begin
          if (req) begin
            lat_we  <= we_i;
            lat_adr <= adr_i[AW-1:0];
            lat_dat <= dat_i;
            cnt     <= WAIT_INIT;
            state   <= ZERO_WAIT ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!cyc_i) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == WAIT_CNT_W'(1)) begin
              state <= ACK;
            end
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  gumnut_dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (clk_en_i),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_gumnut_data_mem.sv
// Bench for gumnut_data_mem. Three instances share one bus:
//   dut_a DEPTH=256 WAIT_STATES=1, dut_b DEPTH=256 WAIT_STATES=0,
//   dut_c DEPTH=16 WAIT_STATES=3.
// A transaction-level model predicts ack/dat/err for each instance.
module tb_gumnut_data_mem;
  import gumnut_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic clk_en;

  gumnut_data_mem_if bus ();

  logic [7:0]  rd_dat [3];
  logic        rd_ack [3];
  logic        rd_err [3];
  dmem_state_e rd_st  [3];

  assign bus.dat_r = rd_dat[0];
  assign bus.ack   = rd_ack[0];
  assign bus.err   = rd_err[0];

  gumnut_data_mem #(.DEPTH(256), .WAIT_STATES(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en), .cyc_i(bus.cyc), .stb_i(bus.stb),
    .we_i(bus.we), .adr_i(bus.adr), .dat_i(bus.dat_w), .dat_o(rd_dat[0]),
    .ack_o(rd_ack[0]), .err_o(rd_err[0]), .state_o(rd_st[0]));

  gumnut_data_mem #(.DEPTH(256), .WAIT_STATES(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en), .cyc_i(bus.cyc), .stb_i(bus.stb),
    .we_i(bus.we), .adr_i(bus.adr), .dat_i(bus.dat_w), .dat_o(rd_dat[1]),
    .ack_o(rd_ack[1]), .err_o(rd_err[1]), .state_o(rd_st[1]));

  gumnut_data_mem #(.DEPTH(16), .WAIT_STATES(3)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en), .cyc_i(bus.cyc), .stb_i(bus.stb),
    .we_i(bus.we), .adr_i(bus.adr), .dat_i(bus.dat_w), .dat_o(rd_dat[2]),
    .ack_o(rd_ack[2]), .err_o(rd_err[2]), .state_o(rd_st[2]));

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  bit rand_en  = 1'b0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each request accepted at enabled edge k is acknowledged after enabled
  // edge k+W, provided cyc stays high on every enabled edge in (k, k+W].
  // The write lands when the ack ends; a read returns the stored byte.
  localparam int W_OF    [3] = '{1, 0, 3};
  localparam int MASK_OF [3] = '{255, 255, 15};

  logic [7:0] m_mem  [3][256];
  bit         m_busy [3];
  bit         m_ack  [3];
  bit         m_err  [3];
  int         m_due  [3];
  bit         m_we   [3];
  int         m_adr  [3];
  logic [7:0] m_wdat [3];
  logic [7:0] m_dat  [3];
  int         e_cnt = 0;
`ifdef GUMNUT_DMEM_PARITY_EN
  bit         m_bad  [3][256];
`endif

  function automatic bit bad_at(input int i, input int a);
`ifdef GUMNUT_DMEM_PARITY_EN
    return m_bad[i][a];
`else
    return 1'b0 & (i == a);
`endif
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i] = 0; m_ack[i] = 0; m_err[i] = 0; m_dat[i] = 8'h00;
      end
    end else if (clk_en) begin
      e_cnt++;
      for (int i = 0; i < 3; i++) begin
        if (m_ack[i]) begin
          if (m_we[i]) begin
            m_mem[i][m_adr[i]] = m_wdat[i];
`ifdef GUMNUT_DMEM_PARITY_EN
            m_bad[i][m_adr[i]] = 1'b0;
`endif
          end
          m_ack[i] = 0; m_err[i] = 0; m_busy[i] = 0;
        end else if (m_busy[i]) begin
          if (!bus.cyc) m_busy[i] = 0;
          else if (e_cnt == m_due[i]) begin
            m_ack[i] = 1;
            if (!m_we[i]) begin
              m_dat[i] = m_mem[i][m_adr[i]];
              m_err[i] = bad_at(i, m_adr[i]);
            end
          end
        end else if (bus.cyc && bus.stb) begin
          m_we[i]   = bus.we;
          m_adr[i]  = int'(bus.adr) & MASK_OF[i];
          m_wdat[i] = bus.dat_w;
          m_busy[i] = 1;
          m_due[i]  = e_cnt + W_OF[i];
          if (W_OF[i] == 0) begin
            m_ack[i] = 1;
            if (!m_we[i]) begin
              m_dat[i] = m_mem[i][m_adr[i]];
              m_err[i] = bad_at(i, m_adr[i]);
            end
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        check("ack", i, 32'(rd_ack[i]), 32'(m_ack[i]));
        check("dat", i, 32'(rd_dat[i]), 32'(m_dat[i]));
        check("err", i, 32'(rd_err[i]), 32'(m_err[i]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until one enabled edge has passed.
  task automatic step();
    bit en;
    do begin
      clk_en = rand_en ? ($urandom_range(0, 7) != 0) : 1'b1;
      @(posedge clk);
      en = clk_en;
      @(negedge clk);
    end while (!en);
  endtask

  // hold = enabled edges after acceptance with cyc still high (3 = complete)
  task automatic xfer(input bit we, input logic [7:0] adr, input logic [7:0] dat,
                      input int hold);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = adr; bus.dat_w = dat;
    step();
    bus.stb   = 1'b0;
    bus.we    = 1'($urandom_range(0, 1));
    bus.adr   = 8'($urandom);
    bus.dat_w = 8'($urandom);
    for (int k = 0; k < hold; k++) step();
    bus.cyc = 1'b0;
    step();
    clk_en = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    bit found;
    int hold;
    rst_n = 1'b0; clk_en = 1'b1;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = 8'h00; bus.dat_w = 8'h00;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      check("rst_ack", i, 32'(rd_ack[i]), 32'd0);
      check("rst_dat", i, 32'(rd_dat[i]), 32'h00);
      check("rst_err", i, 32'(rd_err[i]), 32'd0);
      check("rst_state", i, 32'(rd_st[i]), 32'(IDLE));
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;

    // Fill every location with adr ^ 5A so all later reads are defined.
    for (int a = 0; a < 256; a++) xfer(1'b1, 8'(a), 8'(a) ^ 8'h5A, 3);

    // Write A5 to 10 with exact ack timing.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 8'h10; bus.dat_w = 8'hA5;
    tick();
    check("wr_ack_n0", 0, 32'(rd_ack[0]), 32'd0);
    check("wr_ack_n0", 1, 32'(rd_ack[1]), 32'd1);
    check("wr_ack_n0", 2, 32'(rd_ack[2]), 32'd0);
    bus.stb = 1'b0;
    tick();
    check("wr_ack_n1", 0, 32'(rd_ack[0]), 32'd1);
    check("wr_ack_n1", 1, 32'(rd_ack[1]), 32'd0);
    tick();
    check("wr_ack_n2", 0, 32'(rd_ack[0]), 32'd0);
    tick();
    check("wr_ack_n3", 2, 32'(rd_ack[2]), 32'd1);
    bus.cyc = 1'b0;
    tick();
    check("wr_ack_n4", 2, 32'(rd_ack[2]), 32'd0);

    xfer(1'b0, 8'h10, 8'h00, 3);
    for (int i = 0; i < 3; i++) check("rd_10", i, 32'(rd_dat[i]), 32'hA5);

    // Abort during WAIT: only the zero-wait instance writes.
    xfer(1'b1, 8'h20, 8'h3C, 0);
    xfer(1'b0, 8'h20, 8'h00, 3);
    check("abort_rd", 0, 32'(rd_dat[0]), 32'h7A);
    check("abort_rd", 1, 32'(rd_dat[1]), 32'h3C);
    check("abort_rd", 2, 32'(rd_dat[2]), 32'hA5);

    // Address aliasing in the 16-byte instance.
    xfer(1'b1, 8'h05, 8'h77, 3);
    xfer(1'b0, 8'h15, 8'h00, 3);
    check("alias_rd", 0, 32'(rd_dat[0]), 32'h4F);
    check("alias_rd", 1, 32'(rd_dat[1]), 32'h4F);
    check("alias_rd", 2, 32'(rd_dat[2]), 32'h77);

    // Reset while a write is pending.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 8'h30; bus.dat_w = 8'hEE;
    tick();
    bus.stb = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("midrst_ack", i, 32'(rd_ack[i]), 32'd0);
      check("midrst_dat", i, 32'(rd_dat[i]), 32'h00);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.cyc = 1'b0;
    tick();
    xfer(1'b0, 8'h30, 8'h00, 3);
    check("rst_discard", 0, 32'(rd_dat[0]), 32'h6A);
    check("rst_discard", 1, 32'(rd_dat[1]), 32'h6A);
    check("rst_discard", 2, 32'(rd_dat[2]), 32'hA5);

    // Clock-enable stall of 3 cycles in WAIT stretches latency 1 -> 4.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 8'h05;
    tick();
    bus.stb = 1'b0;
    clk_en = 1'b0;
    repeat (3) tick();
    clk_en = 1'b1;
    lat = 3;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      lat++;
      if (rd_ack[0]) found = 1'b1;
    end
    check("stall_latency", 0, 32'(lat), 32'd4);
    check("stall_dat", 0, 32'(rd_dat[0]), 32'h77);
    tick();
    tick();
    bus.cyc = 1'b0;
    tick();

`ifdef GUMNUT_DMEM_PARITY_EN
    // Corrupt one stored bit of 10 in dut_a; the next read must flag it.
    dut_a.u_array.mem[16][0] = ~dut_a.u_array.mem[16][0];
    m_mem[0][16] = m_mem[0][16] ^ 8'h01;
    m_bad[0][16] = 1'b1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 8'h10;
    tick();
    bus.stb = 1'b0;
    tick();
    check("par_ack", 0, 32'(rd_ack[0]), 32'd1);
    check("par_err", 0, 32'(rd_err[0]), 32'd1);
    tick();
    check("par_err_end", 0, 32'(rd_err[0]), 32'd0);
    tick();
    bus.cyc = 1'b0;
    tick();
`endif

    // Randomised traffic with clock-enable gaps and aborts.
    rand_en = 1'b1;
    repeat (200) begin
      hold = $urandom_range(0, 5);
      if (hold > 3) hold = 3;
      xfer(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), hold);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_en = 1'b0;
    clk_en  = 1'b1;
    repeat (3) tick();
    chk_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
